// File: rtl/adder_arch_compare_pkg.sv
// Shared constants for the adder architecture comparison block.
//   ADDER_W : default operand/sum width in bits
package adder_arch_compare_pkg;

  localparam int ADDER_W = 4;

endpackage

// File: rtl/adder_arch_compare_full_adder.sv
// Single-bit full adder cell used by the ripple-carry core.
// Ports:
//   a, b : operand bits
//   ci   : carry-in
//   s    : sum bit
//   co   : carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (p & ci);

endmodule

// File: rtl/adder_arch_compare.sv
// N-bit unsigned adder built three ways (ripple-carry, flat carry-lookahead,
// behavioural) from the same operands. Each result is registered separately
// and a registered flag reports any disagreement between them.
// Ports:
//   clk              : rising-edge clock
//   rst_n            : synchronous active-low reset
//   a, b             : N-bit unsigned operands
//   cin              : carry-in
//   s_ra, cout_ra    : registered ripple-carry sum / carry-out
//   s_cla, cout_cla  : registered lookahead sum / carry-out
//   s_beh, cout_beh  : registered behavioural sum / carry-out
//   mismatch         : registered flag, set when the three results differ
module adder_arch_compare
  import adder_arch_compare_pkg::*;
#(
  parameter int N = ADDER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s_ra,
  output logic         cout_ra,
  output logic [N-1:0] s_cla,
  output logic         cout_cla,
  output logic [N-1:0] s_beh,
  output logic         cout_beh,
  output logic         mismatch
);

  // ripple-carry core
  logic [N:0]   c_ra;
  logic [N-1:0] sum_ra;

  assign c_ra[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_ripple
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c_ra[i]),
      .s  (sum_ra[i]),
      .co (c_ra[i+1])
    );
  end

  // flat carry-lookahead core
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:1]   parOr;
  logic [N:0]   c_cla;
  logic [N-1:0] sum_cla;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is one OR over independent product terms; no carry feeds
  // another, so the depth stays two levels regardless of N.
  for (genvar k = 1; k <= N; k++) begin : g_carry
    logic [k:0] term;

    always_comb begin
      term = '0;
      for (int j = 0; j < k; j++) begin
        term[j] = g[j];
        for (int m = j + 1; m < k; m++) begin
          term[j] = term[j] & p[m];
        end
      end
      term[k] = cin;
      for (int m = 0; m < k; m++) begin
        term[k] = term[k] & p[m];
      end
    end

    assign parOr[k] = |term;
  end

  assign c_cla[0]   = cin;
  assign c_cla[N:1] = parOr;
  assign sum_cla    = p ^ c_cla[N-1:0];

  // behavioural core
  logic [N:0] res_beh;

  assign res_beh = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

  // cross-check
  logic [N:0] res_ra;
  logic [N:0] res_cla;
  logic       mismatch_c;

  assign res_ra     = {c_ra[N], sum_ra};
  assign res_cla    = {c_cla[N], sum_cla};
  assign mismatch_c = (res_ra != res_cla) || (res_ra != res_beh);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ra     <= '0;
      cout_ra  <= 1'b0;
      s_cla    <= '0;
      cout_cla <= 1'b0;
      s_beh    <= '0;
      cout_beh <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      s_ra     <= sum_ra;
      cout_ra  <= c_ra[N];
      s_cla    <= sum_cla;
      cout_cla <= c_cla[N];
      s_beh    <= res_beh[N-1:0];
      cout_beh <= res_beh[N];
      mismatch <= mismatch_c;
    end
  end

endmodule

// File: tb/tb_adder_arch_compare.sv
// Directed and swept checks of adder_arch_compare at N = 4, 1, 8 and 16.
module tb_adder_arch_compare;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // N = 4
  logic [3:0] a4, b4, s4_ra, s4_cla, s4_beh;
  logic       cin4, c4_ra, c4_cla, c4_beh, mm4;
  // N = 1
  logic [0:0] a1, b1, s1_ra, s1_cla, s1_beh;
  logic       cin1, c1_ra, c1_cla, c1_beh, mm1;
  // N = 8
  logic [7:0] a8, b8, s8_ra, s8_cla, s8_beh;
  logic       cin8, c8_ra, c8_cla, c8_beh, mm8;
  // N = 16
  logic [15:0] a16, b16, s16_ra, s16_cla, s16_beh;
  logic        cin16, c16_ra, c16_cla, c16_beh, mm16;

  adder_arch_compare #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4),
    .s_ra(s4_ra), .cout_ra(c4_ra), .s_cla(s4_cla), .cout_cla(c4_cla),
    .s_beh(s4_beh), .cout_beh(c4_beh), .mismatch(mm4)
  );
  adder_arch_compare #(.N(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
    .s_ra(s1_ra), .cout_ra(c1_ra), .s_cla(s1_cla), .cout_cla(c1_cla),
    .s_beh(s1_beh), .cout_beh(c1_beh), .mismatch(mm1)
  );
  adder_arch_compare #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
    .s_ra(s8_ra), .cout_ra(c8_ra), .s_cla(s8_cla), .cout_cla(c8_cla),
    .s_beh(s8_beh), .cout_beh(c8_beh), .mismatch(mm8)
  );
  adder_arch_compare #(.N(16)) u16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16),
    .s_ra(s16_ra), .cout_ra(c16_ra), .s_cla(s16_cla), .cout_cla(c16_cla),
    .s_beh(s16_beh), .cout_beh(c16_beh), .mismatch(mm16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [4:0] exp);
    check({tag, "_ra"},  17'({c4_ra,  s4_ra}),  17'(exp));
    check({tag, "_cla"}, 17'({c4_cla, s4_cla}), 17'(exp));
    check({tag, "_beh"}, 17'({c4_beh, s4_beh}), 17'(exp));
    check({tag, "_mm"},  17'(mm4), 17'(0));
  endtask

  task automatic chk_wide;
    input string tag;
    input logic [16:0] ra, cla, beh, exp;
    input logic mm;
    check({tag, "_ra"},  ra,  exp);
    check({tag, "_cla"}, cla, exp);
    check({tag, "_beh"}, beh, exp);
    check({tag, "_mm"},  17'(mm), 17'(0));
  endtask

  logic [16:0] e1, e8, e16;

  // Randomise the N=1/8/16 instances and record their golden sums.
  task automatic drive_others;
    a1 = 1'($urandom);  b1 = 1'($urandom);  cin1 = 1'($urandom);
    a8 = 8'($urandom);  b8 = 8'($urandom);  cin8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    e1  = 17'(a1)  + 17'(b1)  + 17'(cin1);
    e8  = 17'(a8)  + 17'(b8)  + 17'(cin8);
    e16 = 17'(a16) + 17'(b16) + 17'(cin16);
  endtask

  task automatic chk_others(input string tag);
    chk_wide({tag, "_n1"}, 17'({c1_ra, s1_ra}), 17'({c1_cla, s1_cla}),
             17'({c1_beh, s1_beh}), e1, mm1);
    chk_wide({tag, "_n8"}, 17'({c8_ra, s8_ra}), 17'({c8_cla, s8_cla}),
             17'({c8_beh, s8_beh}), e8, mm8);
    chk_wide({tag, "_n16"}, 17'({c16_ra, s16_ra}), 17'({c16_cla, s16_cla}),
             17'({c16_beh, s16_beh}), e16, mm16);
  endtask

  // back-to-back vectors: a, b, cin, expected {cout,s}
  typedef struct { logic [3:0] a; logic [3:0] b; logic cin; logic [4:0] exp; } vec_t;
  vec_t b2b[5];

  initial begin
    b2b[0] = '{4'd3,  4'd4,  1'b0, 5'd7};
    b2b[1] = '{4'd9,  4'd9,  1'b1, 5'd19};
    b2b[2] = '{4'd7,  4'd8,  1'b1, 5'd16};
    b2b[3] = '{4'd1,  4'd1,  1'b0, 5'd2};
    b2b[4] = '{4'd15, 4'd15, 1'b1, 5'd31};

    rst_n = 1'b0;
    a4 = 4'd15; b4 = 4'd13; cin4 = 1'b0;
    drive_others();

    // reset held for two edges
    tick();
    chk4("rst1", 5'd0);
    tick();
    chk4("rst2", 5'd0);
    check("rst_n16", 17'({c16_ra, s16_ra, mm16}), 17'(0));

    // first edge after release: 15+13 = 28
    rst_n = 1'b1;
    tick();
    chk4("first", 5'd28);

    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    tick();
    chk4("zero", 5'd0);

    // operands wider than N keep only their low bits
    a4 = 4'(20); b4 = 4'd13; cin4 = 1'b0;
    tick();
    chk4("wide20", 5'd17);
    a4 = 4'(30); b4 = 4'd13; cin4 = 1'b0;
    tick();
    chk4("wide30", 5'd27);
    a4 = 4'(200); b4 = 4'(250); cin4 = 1'b0;
    tick();
    chk4("wide200", 5'd18);

    // full propagate chain
    a4 = 4'd15; b4 = 4'd0; cin4 = 1'b1;
    tick();
    chk4("prop", 5'd16);

    // back-to-back, one new vector per cycle
    for (int i = 0; i < 5; i++) begin
      a4 = b2b[i].a; b4 = b2b[i].b; cin4 = b2b[i].cin;
      tick();
      chk4($sformatf("b2b%0d", i), b2b[i].exp);
    end

    // reset mid-stream overrides one edge only
    rst_n = 1'b0;
    a4 = 4'd5; b4 = 4'd5; cin4 = 1'b0;
    tick();
    chk4("midrst", 5'd0);
    rst_n = 1'b1;
    a4 = 4'd6; b4 = 4'd1; cin4 = 1'b1;
    tick();
    chk4("postrst", 5'd8);

    // exhaustive N=4 sweep alongside random sweeps of the other widths
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci);
          drive_others();
          tick();
          chk4($sformatf("ex_%0d_%0d_%0d", ai, bi, ci), 5'(ai + bi + ci));
          chk_others("rnd");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
